// File: rtl/out_bus.sv
// Response-path bus: round-robin drain of per-switch output FIFOs, one response
// at a time, held on the output until the consumer takes it with valid/ready.
module out_bus #(
    parameter int unsigned NUM_SW_INST = 5,
    parameter int unsigned W_WIDTH     = 8,
    parameter int unsigned FRAME_WIDTH = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_SW_INST-1:0]             fifo_empty,
    input  logic [NUM_SW_INST*FRAME_WIDTH-1:0] fifo_rd_data,
    output logic [NUM_SW_INST-1:0]             fifo_rd_en,
    input  logic                               rdy,
    output logic                               valid_out,
    output logic [7:0]                         op_id_out,
    output logic [W_WIDTH-1:0]                 rd_data_out,
    output logic                               wr_rd_out,
    output logic [7:0]                         addr_out
);

    localparam int unsigned IDX_W     = 3;
    localparam int unsigned OP_LSB    = 0;
    localparam int unsigned DATA_LSB  = 8;
    localparam int unsigned WR_BIT    = 16;
    localparam int unsigned RA_LSB    = 17;
    localparam int unsigned RA_W      = 5;
    localparam int unsigned USED_BITS = RA_LSB + RA_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e                   state_q;
    logic [IDX_W-1:0]         grant_q;
    logic [IDX_W-1:0]         last_grant_q;
    logic [NUM_SW_INST-1:0]   rd_en_q;
    logic                     valid_q;
    logic [7:0]               op_id_q;
    logic [W_WIDTH-1:0]       data_q;
    logic                     wr_rd_q;
    logic [7:0]               addr_q;

    logic                     grant_vld_d;
    logic [IDX_W-1:0]         grant_d;
    logic [FRAME_WIDTH-1:0]   frames [NUM_SW_INST];
    logic [FRAME_WIDTH-1:0]   frame;
    logic                     unused_frame_bits;

    // Round-robin search starting just after the last winner, wrapping at NUM_SW_INST.
    always_comb begin : arb_search
        logic [IDX_W:0] cand;
        cand        = '0;
        grant_vld_d = 1'b0;
        grant_d     = '0;
        for (int unsigned k = 1; k <= NUM_SW_INST; k++) begin
            cand = (IDX_W+1)'(last_grant_q) + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_SW_INST)) begin
                cand = cand - (IDX_W+1)'(NUM_SW_INST);
            end
            if (!grant_vld_d && !fifo_empty[cand[IDX_W-1:0]]) begin
                grant_vld_d = 1'b1;
                grant_d     = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_SW_INST; i++) begin
            frames[i] = fifo_rd_data[i*FRAME_WIDTH +: FRAME_WIDTH];
        end
    end

    assign frame = frames[grant_q];

    // Upper frame bits carry no information.
    assign unused_frame_bits = ^frame[FRAME_WIDTH-1:USED_BITS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_SW_INST - 1);
            rd_en_q      <= '0;
            valid_q      <= 1'b0;
            op_id_q      <= '0;
            data_q       <= '0;
            wr_rd_q      <= 1'b0;
            addr_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_vld_d) begin
                        grant_q <= grant_d;
                        rd_en_q <= NUM_SW_INST'(1) << grant_d;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    rd_en_q <= '0;
                    state_q <= S_WAIT;
                end
                // FIFO data for the strobed entry is on the bus this cycle.
                S_WAIT: begin
                    op_id_q      <= frame[OP_LSB +: 8];
                    data_q       <= frame[DATA_LSB +: W_WIDTH];
                    wr_rd_q      <= frame[WR_BIT];
                    addr_q       <= {grant_q, frame[RA_LSB +: RA_W]};
                    valid_q      <= 1'b1;
                    last_grant_q <= grant_q;
                    state_q      <= S_HOLD;
                end
                S_HOLD: begin
                    if (rdy) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    rd_en_q <= '0;
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_en  = rd_en_q;
    assign valid_out   = valid_q;
    assign op_id_out   = op_id_q;
    assign rd_data_out = data_q;
    assign wr_rd_out   = wr_rd_q;
    assign addr_out    = addr_q;

endmodule

// File: tb/tb_out_bus.sv
// Bench for out_bus: queue-based FIFO model, round-robin reference picker and
// per-scenario tasks with inline comparisons; a 5-switch and an 8-switch instance.
module tb_out_bus;

    localparam int NA = 5;
    localparam int NB = 8;
    localparam int FW = 32;

    logic clk = 1'b0;
    logic rst;

    logic [NA-1:0]    a_empty, a_rd_en;
    logic [NA*FW-1:0] a_rd_data;
    logic             a_rdy, a_valid, a_wr;
    logic [7:0]       a_op, a_data, a_addr;

    logic [NB-1:0]    b_empty, b_rd_en;
    logic [NB*FW-1:0] b_rd_data;
    logic             b_rdy, b_valid, b_wr;
    logic [7:0]       b_op, b_data, b_addr;

    wire [24:0] a_fields = {a_op, a_data, a_wr, a_addr};
    wire [24:0] b_fields = {b_op, b_data, b_wr, b_addr};

    int n_tests = 0;
    int n_fail  = 0;
    int m_last_a;
    int m_last_b;

    logic [31:0] qa [NA][$];
    logic [31:0] qb [NB][$];
    logic [31:0] pend_a [NA];
    logic [31:0] pend_b [NB];
    logic [NA-1:0] pend_a_v;
    logic [NB-1:0] pend_b_v;

    always #5 clk = ~clk;

    out_bus #(.NUM_SW_INST(NA), .W_WIDTH(8), .FRAME_WIDTH(FW)) dut_a (
        .clk(clk), .rst(rst), .fifo_empty(a_empty), .fifo_rd_data(a_rd_data),
        .fifo_rd_en(a_rd_en), .rdy(a_rdy), .valid_out(a_valid), .op_id_out(a_op),
        .rd_data_out(a_data), .wr_rd_out(a_wr), .addr_out(a_addr)
    );

    out_bus #(.NUM_SW_INST(NB), .W_WIDTH(8), .FRAME_WIDTH(FW)) dut_b (
        .clk(clk), .rst(rst), .fifo_empty(b_empty), .fifo_rd_data(b_rd_data),
        .fifo_rd_en(b_rd_en), .rdy(b_rdy), .valid_out(b_valid), .op_id_out(b_op),
        .rd_data_out(b_data), .wr_rd_out(b_wr), .addr_out(b_addr)
    );

    // Reference arbitration: first non-empty index after 'last', modulo n.
    function automatic int rr_pick(int last, int n, logic [7:0] ne);
        for (int k = 1; k <= n; k++) begin
            if (ne[(last + k) % n]) return (last + k) % n;
        end
        return -1;
    endfunction

    function automatic logic [7:0] mask_a();
        logic [7:0] m = '0;
        for (int i = 0; i < NA; i++) m[i] = (qa[i].size() != 0);
        return m;
    endfunction

    function automatic logic [7:0] mask_b();
        logic [7:0] m = '0;
        for (int i = 0; i < NB; i++) m[i] = (qb[i].size() != 0);
        return m;
    endfunction

    // Expected {op_id, data, wr_rd, addr} for a frame served from switch idx.
    function automatic logic [24:0] exp_fields(int idx, logic [31:0] f);
        logic [2:0] ix = 3'(idx);
        return {f[7:0], f[15:8], f[16], ix, f[21:17]};
    endfunction

    function automatic logic [31:0] rand_frame();
        return $urandom | 32'h1;
    endfunction

    task automatic refresh();
        for (int i = 0; i < NA; i++) a_empty[i] = (qa[i].size() == 0);
        for (int i = 0; i < NB; i++) b_empty[i] = (qb[i].size() == 0);
    endtask

    // Advance to the next falling edge and run the FIFO model: a strobe seen in
    // one cycle yields its entry on the bus only in the following cycle.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NA; i++) begin
            if (pend_a_v[i]) begin a_rd_data[i*FW +: FW] = pend_a[i]; pend_a_v[i] = 1'b0; end
            if (a_rd_en[i] && qa[i].size() != 0) begin
                pend_a[i] = qa[i].pop_front();
                pend_a_v[i] = 1'b1;
                a_rd_data[i*FW +: FW] = $urandom;
            end
        end
        for (int i = 0; i < NB; i++) begin
            if (pend_b_v[i]) begin b_rd_data[i*FW +: FW] = pend_b[i]; pend_b_v[i] = 1'b0; end
            if (b_rd_en[i] && qb[i].size() != 0) begin
                pend_b[i] = qb[i].pop_front();
                pend_b_v[i] = 1'b1;
                b_rd_data[i*FW +: FW] = $urandom;
            end
        end
        refresh();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        m_last_a = NA - 1;
        m_last_b = NB - 1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            a_rdy = 1'($urandom);
            b_rdy = 1'($urandom);
            tick();
            n_tests++;
            if ({a_valid, a_rd_en, a_fields} !== '0) begin
                n_fail++;
                $display("FAIL reset_idle_a cyc %0d: got v=%b en=%b f=%h, want all 0", c, a_valid, a_rd_en, a_fields);
            end
            n_tests++;
            if ({b_valid, b_rd_en, b_fields} !== '0) begin
                n_fail++;
                $display("FAIL reset_idle_b cyc %0d: got v=%b en=%b f=%h, want all 0", c, b_valid, b_rd_en, b_fields);
            end
        end
    endtask

    task automatic test_single();
        a_rdy = 1'b1;
        qa[2].push_back(32'h0006_A53C);
        refresh();
        tick();
        n_tests++;
        if (a_rd_en !== 5'b00100 || a_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_rd_en: got en=%b v=%b, want 00100 0", a_rd_en, a_valid);
        end
        tick();
        n_tests++;
        if (a_rd_en !== 5'b00000 || a_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_wait: got en=%b v=%b, want 00000 0", a_rd_en, a_valid);
        end
        tick();
        n_tests++;
        if ({a_valid, a_op, a_data, a_wr, a_addr} !== {1'b1, 8'h3C, 8'hA5, 1'b0, 8'h43}) begin
            n_fail++;
            $display("FAIL single_resp: got v=%b op=%h d=%h wr=%b addr=%h, want 1 3c a5 0 43",
                     a_valid, a_op, a_data, a_wr, a_addr);
        end
        tick();
        n_tests++;
        if (a_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got v=%b, want 0", a_valid);
        end
        m_last_a = 2;
        a_rdy = 1'b0;
    endtask

    task automatic test_round_robin();
        int w;
        logic [31:0] f;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            qa[0].push_back(rand_frame());
            qa[1].push_back(rand_frame());
            qa[4].push_back(rand_frame());
        end
        refresh();
        a_rdy = 1'b1;
        for (int k = 0; k < 9; k++) begin
            w = rr_pick(m_last_a, NA, mask_a());
            f = qa[w][0];
            tick();
            n_tests++;
            if (a_rd_en !== NA'(1 << w)) begin
                n_fail++;
                $display("FAIL rr_grant #%0d: got en=%b, want index %0d", k, a_rd_en, w);
            end
            tick();
            tick();
            n_tests++;
            if ({a_valid, a_fields} !== {1'b1, exp_fields(w, f)}) begin
                n_fail++;
                $display("FAIL rr_resp #%0d: got v=%b f=%h, want 1 %h", k, a_valid, a_fields, exp_fields(w, f));
            end
            m_last_a = w;
            tick();
            n_tests++;
            if (a_valid !== 1'b0 || a_rd_en !== '0) begin
                n_fail++;
                $display("FAIL rr_gap #%0d: got v=%b en=%b, want 0 0", k, a_valid, a_rd_en);
            end
        end
        a_rdy = 1'b0;
    endtask

    task automatic test_backpressure();
        int w, idx;
        logic [31:0] f;
        a_rdy = 1'b0;
        idx = $urandom_range(0, NA - 1);
        qa[idx].push_back(rand_frame());
        refresh();
        for (int t = 0; t < 2; t++) begin
            w = rr_pick(m_last_a, NA, mask_a());
            f = qa[w][0];
            tick();
            n_tests++;
            if (a_rd_en !== NA'(1 << w)) begin
                n_fail++;
                $display("FAIL bp_grant #%0d: got en=%b, want index %0d", t, a_rd_en, w);
            end
            tick();
            tick();
            n_tests++;
            if ({a_valid, a_fields} !== {1'b1, exp_fields(w, f)}) begin
                n_fail++;
                $display("FAIL bp_resp #%0d: got v=%b f=%h, want 1 %h", t, a_valid, a_fields, exp_fields(w, f));
            end
            m_last_a = w;
            if (t == 0) begin
                qa[(idx + 1) % NA].push_back(rand_frame());
                refresh();
            end
            for (int j = 0; j < 6; j++) begin
                tick();
                n_tests++;
                if ({a_valid, a_rd_en, a_fields} !== {1'b1, NA'(0), exp_fields(w, f)}) begin
                    n_fail++;
                    $display("FAIL bp_hold #%0d cyc %0d: got v=%b en=%b f=%h, want 1 0 %h",
                             t, j, a_valid, a_rd_en, a_fields, exp_fields(w, f));
                end
            end
            a_rdy = 1'b1;
            tick();
            a_rdy = 1'b0;
            n_tests++;
            if (a_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_release #%0d: got v=%b, want 0", t, a_valid);
            end
        end
    endtask

    task automatic test_reset_midflight();
        int w;
        logic [31:0] f;
        a_rdy = 1'b1;
        qa[0].push_back(rand_frame());
        qa[0].push_back(rand_frame());
        qa[2].push_back(rand_frame());
        refresh();
        // First serve one entry so the pointer sits on 0, then 2 is next in line.
        for (int t = 0; t < 2; t++) begin
            w = rr_pick(m_last_a, NA, (t == 0) ? 8'h01 : mask_a());
            f = qa[w][0];
            if (t == 0) begin
                a_empty = 5'b11110;
            end
            tick();
            n_tests++;
            if (a_rd_en !== NA'(1 << w)) begin
                n_fail++;
                $display("FAIL mid_grant #%0d: got en=%b, want index %0d", t, a_rd_en, w);
            end
            if (t == 0) begin
                tick();
                tick();
                n_tests++;
                if ({a_valid, a_fields} !== {1'b1, exp_fields(w, f)}) begin
                    n_fail++;
                    $display("FAIL mid_pre_resp: got v=%b f=%h, want 1 %h", a_valid, a_fields, exp_fields(w, f));
                end
                m_last_a = w;
                tick();
            end
        end
        tick();
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({a_valid, a_rd_en, a_fields} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b en=%b f=%h, want all 0", a_valid, a_rd_en, a_fields);
        end
        m_last_a = NA - 1;
        tick();
        rst = 1'b0;
        w = rr_pick(m_last_a, NA, mask_a());
        f = qa[w][0];
        tick();
        n_tests++;
        if (a_rd_en !== 5'b00001 || w != 0) begin
            n_fail++;
            $display("FAIL post_reset_grant: got en=%b, want 00001", a_rd_en);
        end
        tick();
        tick();
        n_tests++;
        if ({a_valid, a_fields} !== {1'b1, exp_fields(0, f)}) begin
            n_fail++;
            $display("FAIL post_reset_resp: got v=%b f=%h, want 1 %h", a_valid, a_fields, exp_fields(0, f));
        end
        m_last_a = 0;
        tick();
        a_rdy = 1'b0;
    endtask

    task automatic test_wrap_b();
        int w;
        logic [31:0] f;
        logic [7:0] sets [3];
        sets[0] = 8'h80;
        sets[1] = 8'h01;
        sets[2] = 8'h88;
        b_rdy = 1'b1;
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < NB; i++) if (sets[s][i]) qb[i].push_back(rand_frame());
            refresh();
            while (mask_b() != 0) begin
                w = rr_pick(m_last_b, NB, mask_b());
                f = qb[w][0];
                tick();
                n_tests++;
                if (b_rd_en !== NB'(1 << w)) begin
                    n_fail++;
                    $display("FAIL wrap_grant set %0d: got en=%b, want index %0d", s, b_rd_en, w);
                end
                tick();
                tick();
                n_tests++;
                if ({b_valid, b_fields} !== {1'b1, exp_fields(w, f)}) begin
                    n_fail++;
                    $display("FAIL wrap_resp set %0d: got v=%b addr=%h f=%h, want 1 %h",
                             s, b_valid, b_addr, b_fields, exp_fields(w, f));
                end
                m_last_b = w;
                tick();
            end
        end
        b_rdy = 1'b0;
    endtask

    task automatic test_random();
        int w, h, npush;
        logic [31:0] f;
        for (int k = 0; k < 40 || mask_a() != 0; k++) begin
            if (k < 40) begin
                npush = $urandom_range(0, 3);
                for (int j = 0; j < npush; j++) qa[$urandom_range(0, NA - 1)].push_back(rand_frame());
                if (mask_a() == 0) qa[$urandom_range(0, NA - 1)].push_back(rand_frame());
            end
            refresh();
            w = rr_pick(m_last_a, NA, mask_a());
            f = qa[w][0];
            a_rdy = 1'($urandom);
            tick();
            n_tests++;
            if (a_rd_en !== NA'(1 << w) || a_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd_grant #%0d: got en=%b v=%b, want index %0d", k, a_rd_en, a_valid, w);
            end
            a_rdy = 1'($urandom);
            tick();
            h = $urandom_range(0, 3);
            a_rdy = (h == 0);
            tick();
            n_tests++;
            if ({a_valid, a_rd_en, a_fields} !== {1'b1, NA'(0), exp_fields(w, f)}) begin
                n_fail++;
                $display("FAIL rnd_resp #%0d: got v=%b en=%b f=%h, want 1 0 %h", k, a_valid, a_rd_en, a_fields, exp_fields(w, f));
            end
            m_last_a = w;
            for (int j = 0; j < h; j++) begin
                tick();
                n_tests++;
                if ({a_valid, a_rd_en, a_fields} !== {1'b1, NA'(0), exp_fields(w, f)}) begin
                    n_fail++;
                    $display("FAIL rnd_hold #%0d cyc %0d: got v=%b en=%b f=%h", k, j, a_valid, a_rd_en, a_fields);
                end
                if (k < 40 && $urandom_range(0, 1) == 1) qa[$urandom_range(0, NA - 1)].push_back(rand_frame());
                refresh();
                a_rdy = (j == h - 1);
            end
            tick();
            n_tests++;
            if (a_valid !== 1'b0 || a_rd_en !== '0) begin
                n_fail++;
                $display("FAIL rnd_done #%0d: got v=%b en=%b, want 0 0", k, a_valid, a_rd_en);
            end
            a_rdy = 1'($urandom);
        end
        a_rdy = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        a_rdy    = 1'b0;
        b_rdy    = 1'b0;
        pend_a_v = '0;
        pend_b_v = '0;
        for (int i = 0; i < NA; i++) a_rd_data[i*FW +: FW] = $urandom;
        for (int i = 0; i < NB; i++) b_rd_data[i*FW +: FW] = $urandom;
        refresh();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        test_wrap_b();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/out_bus.md
Name: out_bus

Overview:
- Response-path bus that drains per-switch output FIFOs and presents one response at a time to the host side.
- Arbitrates round-robin among NUM_SW_INST non-empty switch FIFOs and issues a one-cycle read strobe to the winner.
- Unpacks the returned FRAME_WIDTH-bit frame into op_id, data, address and op-type fields.
- Holds each response until the consumer accepts it with a valid/ready handshake.

Parameters:
- NUM_SW_INST, 5: number of switch instances and FIFOs; range 1..8, because the switch index occupies 3 bits.
- W_WIDTH, 8: data field width.
- FRAME_WIDTH, 32: width of each FIFO entry.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- fifo_empty  input  NUM_SW_INST  per-switch FIFO empty flags.
- fifo_rd_data  input  NUM_SW_INST*FRAME_WIDTH  flattened FIFO read data; slice i = [i*FRAME_WIDTH +: FRAME_WIDTH].
- fifo_rd_en  output  NUM_SW_INST  one-hot read strobe, registered.
- rdy  input  1  consumer ready.
- valid_out  output  1  response valid.
- op_id_out  output  8  operation id, frame bits [7:0].
- rd_data_out  output  W_WIDTH  data, frame bits [15:8].
- wr_rd_out  output  1  op type, frame bit [16].
- addr_out  output  8  {switch index[2:0], reg addr = frame bits [21:17]}.

Behaviour:
- Frame layout: {zero[31:22], reg_addr[21:17], wr_rd_s[16], data[15:8], op_id[7:0]}.
  - Bits [31:22] are ignored.
  - Bit slicing is fixed for W_WIDTH=8.
- FIFO contract: read data is valid on fifo_rd_data in the cycle after fifo_rd_en is sampled high.
- Reset (asynchronous, any time, including mid-transfer):
  - state=IDLE.
  - fifo_rd_en=0, valid_out=0; all output fields = 0.
  - last_grant = NUM_SW_INST-1, so the first search starts at index 0.
  - An in-flight frame is discarded; the FIFO entry already popped is lost.
- FSM states: IDLE, READ, WAIT, HOLD.
  - IDLE: if any fifo_empty bit is 0, pick the winner (see arbitration), latch the grant index, go to READ. Otherwise stay.
  - READ: fifo_rd_en = one-hot(grant) for exactly this cycle; go to WAIT.
  - WAIT: fifo_rd_en=0. At the clock edge, capture slice[grant] into the output registers and build addr_out = {grant[2:0], reg_addr}. Set valid_out=1 and last_grant=grant; go to HOLD.
  - HOLD: valid_out=1 and all fields stable. If rdy=1 this cycle, the transfer completes: next cycle valid_out=0, go to IDLE. If rdy=0, stay; fields must not change.
- Arbitration:
  - Search from (last_grant+1) mod NUM_SW_INST upward with wrap-around; the first non-empty index wins.
  - The wrap from index NUM_SW_INST-1 back to 0 is required.
  - Empty flags are sampled only in IDLE; changes in other states are ignored.
- Timing:
  - Non-empty seen in IDLE at cycle N → fifo_rd_en high at N+1 → valid_out high at N+3.
  - Minimum of 4 cycles per response when rdy is held high.
- Never more than one outstanding read; fifo_rd_en is never asserted while valid_out=1.
- rdy while valid_out=0 has no effect.
- All-empty: remain in IDLE; outputs keep their last values with valid_out=0. Output fields are don't-care when valid_out=0, but equal 0 after reset.

Test Plan:
1. Reset, all FIFOs empty → fifo_rd_en=0 and valid_out=0 held for 20 cycles; all outputs 0.
2. Only FIFO 2 non-empty with frame 0x0006_A5_3C (reg_addr=3, wr_rd=0, data=0xA5, op_id=0x3C), rdy=1 → fifo_rd_en=5'b00100 one cycle; three cycles after IDLE detect: valid_out=1, op_id_out=0x3C, rd_data_out=0xA5, wr_rd_out=0, addr_out=8'h43.
3. FIFOs 0, 1 and 4 non-empty continuously, rdy=1 → grant order 0,1,4,0,1,4 with 4-cycle spacing. Starting with last_grant=4 gives the order 0,1,4.
4. Backpressure: rdy=0 for 6 cycles after valid_out rises → valid_out and all fields stable, no fifo_rd_en pulses. Raising rdy gives exactly one transfer, then valid_out=0 the next cycle.
5. rst asserted during WAIT → outputs go to 0 immediately (asynchronously), state IDLE. After release, the next grant is index 0 if FIFO 0 is non-empty.
6. NUM_SW_INST=8, only FIFO 7 then FIFO 0 non-empty → addr_out[7:5]=3'b111, then 3'b000; the pointer wraps correctly.
